bsg_nonsynth_clock_div_gen: RTL

//  Multi-channel, runtime-programmable clock generator for Verilator/VCS benches; no delay statements.

---
 rtl/bsg_nonsynth_clock_div_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bsg_nonsynth_clock_div_gen.sv
// bsg_nonsynth_clock_div_gen
//   Multi-channel, runtime-programmable clock divider for simulation benches.
//   Every channel derives a 50%-duty clock from clk_i with its own half-period
//   and enable. Reconfiguration is buffered per channel and lands only on a
//   falling boundary (or at once on a stopped channel), so an output never
//   glitches or shortens a high phase.
//
//   Optional feature macro: BSG_NONSYNTH_CLOCK_DIV_GEN_COUNT_EN
//     When defined, cycles_o exposes a per-channel rising-edge counter.
//
// Ports
//   clk_i             bench clock, all state changes on its rising edge
//   reset_i           synchronous active-high reset
//   cfg_v_i           config write valid
//   cfg_id_i          target channel (ids >= num_clk_p are accepted and dropped)
//   cfg_en_i          new enable for the target channel
//   cfg_half_period_i new half-period; 0 stops the channel
//   cfg_ready_o       low while the addressed channel holds an unapplied write
//   clk_o             generated clocks (registered)
//   posedge_o         high during the first clk_i cycle each clk_o[i] is high
//   cycles_o          per-channel rising-edge counts (COUNT_EN only)

module bsg_nonsynth_clock_div_gen_chan #(
    parameter int   width_p            = 16,
    parameter int   init_half_period_p = 1,
    parameter logic init_en_p          = 1'b1,
    parameter int   count_width_p      = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic               i_en,
    input  logic [width_p-1:0] i_hp,
    output logic               o_pending,
    output logic               o_clk,
    output logic               o_posedge
`ifdef BSG_NONSYNTH_CLOCK_DIV_GEN_COUNT_EN
   ,output logic [count_width_p-1:0] o_cycles
`endif
);

    logic               r_en;
    logic [width_p-1:0] r_hp;
    logic [width_p-1:0] r_cnt;
    logic               r_lvl;
    logic               r_posedge;
    logic               r_pending;
    logic               r_p_en;
    logic [width_p-1:0] r_p_hp;

    logic w_last;
    logic w_apply;

    // hp is never 0 (zero writes stop the channel instead of loading hp)
    assign w_last  = (r_cnt == (r_hp - width_p'(1)));
    // a buffered write lands on the falling toggle, or right away when stopped
    assign w_apply = r_pending & (~r_en | (r_lvl & w_last));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_en      <= init_en_p;
            r_hp      <= width_p'(init_half_period_p);
            r_cnt     <= '0;
            r_lvl     <= 1'b0;
            r_posedge <= 1'b0;
            r_pending <= 1'b0;
            r_p_en    <= 1'b0;
            r_p_hp    <= '0;
        end else begin
            r_posedge <= 1'b0;
            if (w_apply) begin
                r_en      <= r_p_en & (r_p_hp != '0);
                if (r_p_hp != '0)
                    r_hp  <= r_p_hp;
                r_cnt     <= '0;
                r_lvl     <= 1'b0;
                r_pending <= 1'b0;
            end else if (r_en) begin
                if (w_last) begin
                    r_lvl     <= ~r_lvl;
                    r_cnt     <= '0;
                    r_posedge <= ~r_lvl;
                end else begin
                    r_cnt <= r_cnt + width_p'(1);
                end
            end
            // accept only happens with pending clear, so it never races apply
            if (i_wr) begin
                r_pending <= 1'b1;
                r_p_en    <= i_en;
                r_p_hp    <= i_hp;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_clk     = r_lvl;
    assign o_posedge = r_posedge;

`ifdef BSG_NONSYNTH_CLOCK_DIV_GEN_COUNT_EN
    logic [count_width_p-1:0] r_cycles;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_cycles <= '0;
        else if (r_posedge)
            r_cycles <= r_cycles + count_width_p'(1);
    end

    assign o_cycles = r_cycles;
`endif

endmodule

module bsg_nonsynth_clock_div_gen #(
    parameter int                   num_clk_p          = 4,
    parameter int                   width_p            = 16,
    parameter int                   init_half_period_p = 1,
    parameter logic [num_clk_p-1:0] init_en_p          = '1,
    parameter int                   count_width_p      = 32,
    localparam int                  id_width_lp        = (num_clk_p > 1) ? $clog2(num_clk_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cfg_v_i,
    input  logic [id_width_lp-1:0] cfg_id_i,
    input  logic                   cfg_en_i,
    input  logic [width_p-1:0]     cfg_half_period_i,
    output logic                   cfg_ready_o,
    output logic [num_clk_p-1:0]   clk_o,
    output logic [num_clk_p-1:0]   posedge_o
`ifdef BSG_NONSYNTH_CLOCK_DIV_GEN_COUNT_EN
   ,output logic [num_clk_p*count_width_p-1:0] cycles_o
`endif
);

    logic [num_clk_p-1:0] w_pending;
    logic [num_clk_p-1:0] w_wr;
    logic                 w_ready;

    // ids that match no channel fall through with ready=1 and write nothing
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < num_clk_p; i++)
            if (cfg_id_i == id_width_lp'(i))
                w_ready = ~w_pending[i];
    end

    assign cfg_ready_o = w_ready;

    for (genvar i = 0; i < num_clk_p; i++) begin : g_chan
        assign w_wr[i] = cfg_v_i & w_ready & (cfg_id_i == id_width_lp'(i));

        bsg_nonsynth_clock_div_gen_chan #(
            .width_p            (width_p),
            .init_half_period_p (init_half_period_p),
            .init_en_p          (init_en_p[i]),
            .count_width_p      (count_width_p)
        ) u_chan (
            .i_clk     (clk_i),
            .i_reset   (reset_i),
            .i_wr      (w_wr[i]),
            .i_en      (cfg_en_i),
            .i_hp      (cfg_half_period_i),
            .o_pending (w_pending[i]),
            .o_clk     (clk_o[i]),
            .o_posedge (posedge_o[i])
`ifdef BSG_NONSYNTH_CLOCK_DIV_GEN_COUNT_EN
           ,.o_cycles  (cycles_o[i*count_width_p +: count_width_p])
`endif
        );
    end

endmodule
